// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with per-register pending-write scoreboard.
package regfile_pkg;
   localparam int          DEF_DATA_WIDTH = 32;
   localparam int          DEF_ADDR_WIDTH = 5;
   localparam int          DEF_SP_INDEX   = 29;
   localparam logic [31:0] DEF_SP_RESET   = 32'h7FFF_EFFC;
   localparam int          DEF_PEND_WIDTH = 2;
   localparam int          DEF_PEND_MAX   = 2**DEF_PEND_WIDTH - 1;
   localparam int          ZERO_REG       = 0;
endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of in-flight writers for one architectural register.
module pending_counter #(
   parameter int W = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   output logic busy_o,
   output logic full_o,
   output logic last_o
);
   localparam logic [W-1:0] MAX = '1;
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   // Simultaneous issue and writeback cancel; decrement at zero is dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && cnt_q != MAX)
         cnt_d = cnt_q + ONE;
      else if (dec_i && !inc_i && cnt_q != '0)
         cnt_d = cnt_q - ONE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign busy_o = (cnt_q != '0);
   assign full_o = (cnt_q == MAX);
   assign last_o = (cnt_q == ONE);
endmodule

// File: rtl/register_file_scoreboard.sv
// MIPS register file, 2 async reads / 1 sync write, with per-register pending-write
// scoreboard driving Stall. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file_scoreboard
   import regfile_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    SP_INDEX   = DEF_SP_INDEX,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = DEF_SP_RESET,
   parameter int                    PEND_WIDTH = DEF_PEND_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   input  logic                  ReadEnable1,
   input  logic                  ReadEnable2,
   input  logic                  Issue,
   input  logic [ADDR_WIDTH-1:0] IssueRegister,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic                  Stall
);
   localparam int NREGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(ZERO_REG);
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [NREGS-1:0]      busy_v, full_v, clr_v;
   logic [NREGS-1:1]      last_v, inc_v, dec_v;
   logic                  accept, busy1, busy2, hit1, hit2;

   assign busy_v[0] = 1'b0;
   assign full_v[0] = 1'b0;

   for (genvar i = 1; i < NREGS; i++) begin : g_pend
      pending_counter #(.W(PEND_WIDTH)) u_pend (
         .clk_i  (clk),
         .rst_ni (reset),
         .inc_i  (inc_v[i]),
         .dec_i  (dec_v[i]),
         .busy_o (busy_v[i]),
         .full_o (full_v[i]),
         .last_o (last_v[i])
      );
   end

   // Writeback side is never blocked; clr marks a write that drains the count to zero.
   always_comb begin
      dec_v = '0;
      clr_v = '0;
      for (int i = 1; i < NREGS; i++) begin
         dec_v[i] = RegWrite && (WriteRegister == ADDR_WIDTH'(i));
         clr_v[i] = dec_v[i] && last_v[i];
      end
   end

   assign busy1 = ReadEnable1 && busy_v[ReadRegister1] && !(BYPASS && clr_v[ReadRegister1]);
   assign busy2 = ReadEnable2 && busy_v[ReadRegister2] && !(BYPASS && clr_v[ReadRegister2]);
   assign Stall = busy1 || busy2 || (Issue && full_v[IssueRegister]);

   assign accept = Issue && !Stall && (IssueRegister != R0);

   always_comb begin
      inc_v = '0;
      for (int i = 1; i < NREGS; i++)
         inc_v[i] = accept && (IssueRegister == ADDR_WIDTH'(i));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end else if (RegWrite && WriteRegister != R0) begin
         regs_q[WriteRegister] <= WriteData;
      end
   end

   assign hit1 = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != R0);
   assign hit2 = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != R0);
   assign ReadData1 = (BYPASS && hit1) ? WriteData : regs_q[ReadRegister1];
   assign ReadData2 = (BYPASS && hit2) ? WriteData : regs_q[ReadRegister2];
endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised MIPS register file with a per-register pending-write scoreboard, replacing the flat array of enable registers in the pipelined datapath. It provides two asynchronous read ports, one synchronous write port (writeback stage), and a hazard `Stall` output driven by in-flight destination counts tracked between issue (decode) and writeback.

## Interface
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: address width; register count is 2**ADDR_WIDTH.
- `SP_INDEX`, 29: index of the stack-pointer register.
- `SP_RESET`, 32'h7FFF_EFFC: reset value of the `SP_INDEX` register.
- `PEND_WIDTH`, 2: pending counter width; max in-flight writers per register = 2**PEND_WIDTH-1.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low.
- `RegWrite` in 1: writeback enable.
- `WriteRegister` in ADDR_WIDTH: writeback destination.
- `WriteData` in DATA_WIDTH: writeback data.
- `ReadRegister1`, `ReadRegister2` in ADDR_WIDTH: source addresses (rs, rt).
- `ReadEnable1`, `ReadEnable2` in 1: the issuing instruction actually uses that source.
- `Issue` in 1: decode wants to issue an instruction with a destination.
- `IssueRegister` in ADDR_WIDTH: destination of the issuing instruction.
- `ReadData1`, `ReadData2` out DATA_WIDTH: combinational read data.
- `Stall` out 1: combinational hazard; issue is refused while high.

## Operation
- Reset (`reset`==0 at rising edge): all registers 0 except `SP_INDEX` = `SP_RESET`; all pending counters 0. Reset takes priority over every other input, including writes and issues in the same cycle.
- Register 0: always reads 0, never written, never pending; `Issue` or `RegWrite` to register 0 is ignored.
- Write: at the edge with `RegWrite`=1 and `WriteRegister`≠0, the register takes `WriteData`.
- Read: `ReadDataN` = contents of `ReadRegisterN` (bypass rule under Configuration).
- Pending counter per register, `pend[i]`:
  - +1 when an issue is accepted: `Issue`=1, `Stall`=0, `IssueRegister`=i≠0.
  - −1 when `RegWrite`=1 and `WriteRegister`=i.
  - Both in the same cycle: the counter is unchanged.
  - A decrement at 0 is ignored (no underflow). An increment at max cannot occur because `Stall` blocks it.
- `Stall` = (`ReadEnable1` & pend[`ReadRegister1`]≠0) | (`ReadEnable2` & pend[`ReadRegister2`]≠0) | (`Issue` & pend[`IssueRegister`]==max).
- A stalled issue leaves every counter unchanged. The writeback side is never blocked.

## Timing
- Read latency: 0 cycles (combinational). Write visible to reads from the cycle after the edge.
- `Stall` is combinational from addresses, enables, and counter state. There is no registered output apart from register and counter state.
- Issue accepted in cycle t: `pend` is nonzero from cycle t+1. Dependent reads stall from t+1 until the writeback edge clears the count.
- Reset mid-operation discards all pending counts. `Stall` is 0 in the first cycle after reset unless `Issue` targets a saturated counter, which is impossible after reset.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read of a register being written this cycle (`RegWrite`, matching non-zero address) returns `WriteData`.
  - The busy term for that source is masked in `Stall`, if the write drops its count to 0.
  - The dependent instruction issues in the writeback cycle.
- Not defined: reads return stored contents, and the busy term uses the current `pend` only. The dependent instruction issues one cycle after writeback.

## Structure
- Package `regfile_pkg`:
  - default `DATA_WIDTH`/`ADDR_WIDTH`;
  - `SP_INDEX`, `SP_RESET`;
  - `PEND_WIDTH` and derived `PEND_MAX`;
  - the zero-register index constant.
- Sub-module `pending_counter`: saturating up/down counter with sync active-low reset, inc/dec inputs, and `busy`/`full` outputs. It is instantiated once per register 1..2**ADDR_WIDTH−1.
- Register storage is a plain array inside the top module.

## Test plan
- Reset, then read 0 and 29 → `ReadData`=0 and 32'h7FFF_EFFC; `Stall`=0.
- Write 0xDEADBEEF to r8 and read r8 in the same cycle → old value 0 without the macro and 0xDEADBEEF with it. Next cycle → 0xDEADBEEF in both builds.
- Issue r9, next cycle read r9 with `ReadEnable1`=1 → `Stall`=1 until the writeback of r9. Clearing `ReadEnable1` → `Stall`=0.
- Issue r10 three times (count 3), a fourth `Issue` r10 → `Stall`=1 and count stays 3. Three writebacks → count 0 and `Stall`=0.
- Issue r11 and write back r11 in the same cycle with count 1 → count stays 1. Issue/write r0 → r0 reads 0 and `Stall` never asserts.
- Drive `reset`=0 with count r12=2 and a pending write → the next cycle shows the count at 0, r12=0, and `Stall`=0.
